// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit producing HI/LO for mult/multu/div/divu.
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_CALC, S_FIX, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic               sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     msum, rsh, diff;
  logic [WIDTH-1:0]   rem_n, quo, rem;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_raw_d  = a_raw_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    sa       = op[0] & a[WIDTH-1];
    sb       = op[0] & b[WIDTH-1];
    abs_a    = sa ? -a : a;
    abs_b    = sb ? -b : b;
    msum     = '0;
    rsh      = '0;
    diff     = '0;
    rem_n    = '0;
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
    prod     = neg_lo_q ? -acc_q : acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_raw_d  = a;
          is_div_d = op[1];
          neg_lo_d = sa ^ sb;
          neg_hi_d = sa;
          dbz_d    = 1'b0;
          cnt_d    = CW'(WIDTH);
          state_d  = S_CALC;
          if (op[1]) begin
            acc_d  = {{WIDTH{1'b0}}, abs_a};
            opnd_d = abs_b;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, abs_b};
            opnd_d = abs_a;
          end
        end
      end
      S_CALC: begin
        if (!is_div_q) begin
          msum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, opnd_q} : '0);
          acc_d = {msum, acc_q[WIDTH-1:1]};
        end else begin
          // borrow out of the W+1 bit subtract means "restore"
          rsh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
          diff  = rsh - {1'b0, opnd_q};
          rem_n = diff[WIDTH] ? rsh[WIDTH-1:0] : diff[WIDTH-1:0];
          acc_d = {rem_n, acc_q[WIDTH-2:0], ~diff[WIDTH]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1))
          state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        if (!is_div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (opnd_q == '0) begin
          hi_d  = a_raw_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = neg_hi_q ? -rem : rem;
          lo_d = neg_lo_q ? -quo : quo;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      a_raw_q  <= a_raw_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
